bus_mem_slave: RTL and testbench

Word-addressed memory responder on the shared system bus: the target-side counterpart to the cache bus masters. It decodes `BUS_addr` against its window, services reads and writes with a programmable number of wait states, and completes each transfer with a four-phase `BUS_req`/`BUS_ready` handshake. It sits on the bus next to `bus_control`, behind whichever master currently holds the grant, and replaces the behavioural memory model with synthesizable RAM.

---
 rtl/bus_mem_slave.sv | 179 +++++++++++++++++
 tb/tb_bus_mem_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_slave.sv
// -----------------------------------------------------------------------------
// bus_mem_slave
//   Word-addressed RAM target on the shared system bus. A request whose upper
//   address bits match the window is latched in IDLE, held for WAIT_CYCLES wait
//   states, serviced in a single ACCESS cycle and then completed with a
//   four-phase BUS_req / BUS_ready handshake.
//
//   With WAIT_CYCLES >= 1, BUS_ready rises WAIT_CYCLES+2 edges after the request
//   is first sampled. With WAIT_CYCLES = 0 the WAIT state is skipped, and
//   BUS_ready rises one edge after the request is first sampled.
//
//   Optional feature macro: BUS_SLAVE_ERRCHK_EN
//     When defined, a misaligned request (BUS_addr[1:0] != 0) still completes
//     the handshake but touches no RAM. A read of this kind returns 32'hDEAD_BEEF,
//     and the sticky err flag is set. When undefined, the byte offset is ignored
//     and err is tied 0.
//
// Parameters
//   BASE_ADDR    byte base of the window, aligned to the window size
//   ADDR_BITS    log2 of the word count
//   WAIT_CYCLES  wait states before completion, 0..15
//
// Ports
//   clk        system clock
//   clr        asynchronous active-low reset
//   BUS_addr   byte address from the granted master
//   BUS_data   bidirectional data; driven here only while completing a read
//   BUS_req    transfer request, held by the master until BUS_ready
//   BUS_RW     1 = write, 0 = read
//   BUS_ready  1 while completing, 0 while selected and waiting, z otherwise
//   busy       high in any state other than IDLE
//   err        sticky misaligned-access flag
// -----------------------------------------------------------------------------
module bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] BUS_addr,
  inout  wire  [31:0] BUS_data,
  input  logic        BUS_req,
  input  logic        BUS_RW,
  inout  wire         BUS_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_READY} state_t;

  localparam int          TAG_LSB   = ADDR_BITS + 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] BAD_WORD  = 32'hDEAD_BEEF;

  state_t                 state, state_nxt;
  logic [3:0]             wait_cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   rw_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   mis_q;
  logic                   sel;
  logic                   ready_oe, ready_val, data_oe;

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  assign sel = BUS_req && (BUS_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments, so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of the block keeps every path
  // assigned, so the logic stays combinational and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sel) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT: begin
        if (!BUS_req)           state_nxt = S_IDLE;   // abort: nothing written
        else if (wait_cnt == 0) state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_READY;
      S_READY:  if (!BUS_req) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and bus drivers
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_oe  = 1'b0;
    ready_val = 1'b0;
    data_oe   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_WAIT,
      S_ACCESS: ready_oe = 1'b1;
      S_READY: begin
        ready_oe  = 1'b1;
        ready_val = 1'b1;
        data_oe   = !rw_q;
      end
      default:  busy = 1'b0;
    endcase
  end

  assign BUS_ready = ready_oe ? ready_val : 1'bz;
  assign BUS_data  = data_oe  ? rdata_q   : 32'hzzzz_zzzz;

  // ---------------------------------------------------------------------------
  // Request capture, wait counter and read register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (sel) begin
          wait_cnt <= WAIT_INIT;
          addr_q   <= BUS_addr[ADDR_BITS+1:2];
          rw_q     <= BUS_RW;
          if (BUS_RW) wdata_q <= BUS_data;
        end
        S_WAIT:   if (wait_cnt != 0) wait_cnt <= wait_cnt - 4'd1;
        S_ACCESS: if (!rw_q) rdata_q <= mis_q ? BAD_WORD : mem[addr_q];
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; its contents survive clr and are
  // undefined at power-up, which lets it map onto plain block RAM.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && rw_q && !mis_q) mem[addr_q] <= wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Optional misaligned-access checking
  // ---------------------------------------------------------------------------
`ifdef BUS_SLAVE_ERRCHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && sel) mis_q <= |BUS_addr[1:0];
      if (state == S_ACCESS && mis_q) err_q <= 1'b1;   // sticky until clr
    end
  end

  assign err = err_q;
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^BUS_addr[1:0];
  assign mis_q           = 1'b0;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_slave
//   Directed bench for bus_mem_slave (BASE_ADDR = 32'h1000, 1024 words,
//   2 wait states). The shared bus nets carry pull-ups, so an undriven (z) bus
//   reads back as all ones. This lets the bench tell "released" apart from
//   "driven 0" on BUS_ready and on BUS_data.
// -----------------------------------------------------------------------------
module tb_bus_mem_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ZD   = 32'hFFFF_FFFF;   // undriven data bus

`ifdef BUS_SLAVE_ERRCHK_EN
  localparam logic [31:0] MIS_RD  = 32'hDEAD_BEEF;
  localparam logic        MIS_ERR = 1'b1;
`else
  localparam logic [31:0] MIS_RD  = 32'h1111_1111;  // word 1 of the window
  localparam logic        MIS_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_drive = 1'b0;
  logic        m_req = 1'b0;
  logic        m_rw = 1'b0;
  logic        busy, err;
  wire  [31:0] bus_data;
  wire         bus_ready;

  int n_checks = 0;
  int n_fail   = 0;

  pullup (bus_data);
  pullup (bus_ready);
  assign bus_data = m_drive ? m_data : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  bus_mem_slave #(
    .BASE_ADDR  (BASE),
    .ADDR_BITS  (10),
    .WAIT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .BUS_addr (m_addr),
    .BUS_data (bus_data),
    .BUS_req  (m_req),
    .BUS_RW   (m_rw),
    .BUS_ready(bus_ready),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete master transfer, started on a falling edge.
  task automatic do_xfer(input string nm, input logic [31:0] addr, input logic rw,
                         input logic [31:0] wdata, input logic in_win,
                         input logic [31:0] exp_rd, input int hold);
    int   lat;
    logic ok;
    m_addr  = addr;
    m_rw    = rw;
    m_data  = wdata;
    m_drive = rw;
    m_req   = 1'b1;
    if (!in_win) begin
      ok = 1'b1;
      repeat (6) begin
        tick();
        if (busy !== 1'b0 || bus_ready !== 1'b1) ok = 1'b0;
        if (!rw && bus_data !== ZD) ok = 1'b0;
      end
      check({nm, ".ignored"}, 32'(ok), 32'd1);
      m_req   = 1'b0;
      m_drive = 1'b0;
      tick();
      return;
    end
    tick();                               // edge N samples the request
    check({nm, ".busy"}, 32'(busy), 32'd1);
    m_data = 32'hBAD0_BAD0;               // write data must already be captured
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        m_drive = 1'b0;
        check({nm, ".wait_ready0"}, 32'(bus_ready), 32'd0);
      end
      if (bus_ready === 1'b1 && busy === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({nm, ".latency"}, lat, 4);
    if (lat != 0) begin
      check({nm, ".data"}, bus_data, rw ? ZD : exp_rd);
      ok = 1'b1;
      repeat (hold) begin
        tick();
        if (bus_ready !== 1'b1 || bus_data !== (rw ? ZD : exp_rd)) ok = 1'b0;
      end
      if (hold > 0) check({nm, ".hold"}, 32'(ok), 32'd1);
    end
    m_req = 1'b0;
    tick();
    check({nm, ".rel_busy"}, 32'(busy), 32'd0);
    check({nm, ".rel_ready"}, 32'(bus_ready), 32'd1);
    check({nm, ".rel_data"}, bus_data, ZD);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic        in_win;
    logic [31:0] exp_rd;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic ok;

    vecs[0]  = '{32'h0000_1010, 1'b1, 32'h0AB2_112B, 1'b1, 32'h0,         0};
    vecs[1]  = '{32'h0000_1010, 1'b0, 32'h0,         1'b1, 32'h0AB2_112B, 0};
    vecs[2]  = '{32'h0000_1004, 1'b1, 32'h1111_1111, 1'b1, 32'h0,         0};
    vecs[3]  = '{32'h0000_1020, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0,         0};
    vecs[4]  = '{32'h0000_1004, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 3};
    vecs[5]  = '{32'h0000_0004, 1'b0, 32'h0,         1'b0, 32'h0,         0};
    vecs[6]  = '{32'h0000_2004, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0,         0};
    vecs[7]  = '{32'h0000_1004, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 0};
    vecs[8]  = '{32'h0000_1FFC, 1'b1, 32'h8000_0001, 1'b1, 32'h0,         0};
    vecs[9]  = '{32'h0000_1FFC, 1'b0, 32'h0,         1'b1, 32'h8000_0001, 1};
    vecs[10] = '{32'h0000_1020, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 0};

    // Reset held with a live request: the block must stay silent.
    m_addr = 32'h0000_1010;
    m_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.busy",  32'(busy), 32'd0);
    check("reset.err",   32'(err), 32'd0);
    check("reset.ready", 32'(bus_ready), 32'd1);
    check("reset.data",  bus_data, ZD);
    m_req = 1'b0;
    clr   = 1'b1;
    @(negedge clk);

    // Table of back-to-back transfers with the minimum idle gap.
    foreach (vecs[i])
      do_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].wdata,
              vecs[i].in_win, vecs[i].exp_rd, vecs[i].hold);

    // Abort: the request drops during WAIT, so no write takes place.
    m_addr = 32'h0000_1020; m_rw = 1'b1; m_data = 32'h1234_5678;
    m_drive = 1'b1; m_req = 1'b1;
    tick();
    m_req = 1'b0; m_drive = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      tick();
      if (busy !== 1'b0) ok = 1'b0;
    end
    check("abort.idle", 32'(ok), 32'd1);
    do_xfer("abort.rd", 32'h0000_1020, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 0);

    // Reset in WAIT: the write is lost.
    do_xfer("rst_wait.pre", 32'h0000_1030, 1'b1, 32'h55AA_55AA, 1'b1, 32'h0, 0);
    m_addr = 32'h0000_1030; m_rw = 1'b1; m_data = 32'h0BAD_F00D;
    m_drive = 1'b1; m_req = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    check("rst_wait.busy", 32'(busy), 32'd0);
    m_req = 1'b0; m_drive = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    do_xfer("rst_wait.rd", 32'h0000_1030, 1'b0, 32'h0, 1'b1, 32'h55AA_55AA, 0);

    // Reset in READY: the write has already committed.
    m_addr = 32'h0000_1040; m_rw = 1'b1; m_data = 32'h1357_9BDF;
    m_drive = 1'b1; m_req = 1'b1;
    tick();
    m_drive = 1'b0;
    repeat (4) tick();
    check("rst_ready.ready", 32'(bus_ready), 32'd1);
    clr = 1'b0;
    #1;
    check("rst_ready.busy", 32'(busy), 32'd0);
    m_req = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    do_xfer("rst_ready.rd", 32'h0000_1040, 1'b0, 32'h0, 1'b1, 32'h1357_9BDF, 0);

    // Misaligned read, followed by a sticky-flag check and its clear by reset.
    do_xfer("mis.rd", 32'h0000_1006, 1'b0, 32'h0, 1'b1, MIS_RD, 0);
    check("mis.err", 32'(err), 32'(MIS_ERR));
    do_xfer("mis.next", 32'h0000_1010, 1'b0, 32'h0, 1'b1, 32'h0AB2_112B, 0);
    check("mis.sticky", 32'(err), 32'(MIS_ERR));
    clr = 1'b0;
    @(negedge clk);
    check("mis.clr", 32'(err), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
